spi_display_multi: RTL
======================

# spi_display_multi

Parametrised bit-bang SPI master for display/peripheral command streams, successor to the fixed 8-bit single-device display driver. It pulls {dc, select, data} words from a first-word-fall-through source (ROM sequencer or FIFO) through a get/empty handshake, and shifts each word out at a rate set by an external strobe. Word width, chip-select count, SPI mode and bit order are configurable, and MISO read-back is supported. It sits between a command source and the display pins.

## Interface

- W, 8: data word width in bits (≥2)
- CS, 1: number of chip-select lines (≥1); SW = (CS > 1) ? $clog2(CS) : 1
- CPOL, 0: idle level of spi_clock
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge
- LSB, 0: 0 = MSB first, 1 = LSB first

- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high
- step  in  1  half-bit strobe; one SPI edge per step-qualified clock
- in_dc  in  1  data/command flag of the presented word
- in_sel  in  SW  target chip-select index of the presented word
- in_data  in  W  word to send
- get  out  1  consume strobe to source (combinational)
- empty  in  1  source has no word; in_* invalid
- spi_cs_n  out  CS  active-low selects, one-hot-low when active
- spi_clock  out  1  SPI clock
- spi_dc  out  1  registered in_dc of the word in flight
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- out_data  out  W  last received word
- out_valid  out  1  one-clock pulse: out_data updated

## Operation

- Reset values: spi_cs_n all 1, spi_clock = CPOL, spi_dc = 0, spi_mosi = 0, out_data = 0, out_valid = 0; state IDLE; all counters 0.
- States: IDLE, SHIFT, STOP.
- IDLE: when step && !empty: get = 1, latch in_data/in_dc/in_sel, drive spi_cs_n[in_sel] = 0, spi_dc = in_dc; if CPHA = 0, present the first bit on spi_mosi; edge counter = 0; go to SHIFT. step with empty = 1 does nothing.
- SHIFT: each step toggles spi_clock and increments the edge counter (0..2W).
  - Leading edges (odd count): CPHA = 0 samples MISO; CPHA = 1 drives the next bit.
  - Trailing edges (even count): CPHA = 0 drives the next bit; CPHA = 1 samples MISO.
  - Bit order: MSB first unless LSB = 1; the receive register uses the same order.
- Edge 2W step (spi_clock back at CPOL):
  - If !empty && in_sel == latched sel: get = 1, load the next word and dc in the same cycle, CPHA = 0 presents its first bit, counter = 0, stay in SHIFT. CS is not deasserted.
  - Otherwise go to STOP.
- STOP: on the next step, spi_cs_n all 1, spi_mosi = 0, go to IDLE. A new word may be loaded only by a later step in IDLE.
- get is asserted only in the two load cases above, for exactly one clock, and never while empty = 1.
- Read-back: on the clock after the edge-2W step, out_data = received word and out_valid = 1 for one clock. Completed words only.
- Reset at any time: outputs return to reset values immediately. The word in flight is discarded, no out_valid is issued, and get stays 0 until the IDLE load condition holds.

## Timing

- step may be high on consecutive clocks; the minimum SPI half-period is one clock.
- Per word: 2W step-qualified edges. CS-low span for a single word: load step + 2W edge steps + STOP step.
- Back-to-back words to the same select: no idle step and no CS gap. The first edge of word n+1 is the step after the last edge of word n.
- Select change or empty at word end costs one STOP step plus one IDLE load step before the next first edge.
- spi_dc changes only at load steps, so it is stable across the whole word.
- out_valid latency: 1 clock after the final edge step.

## Test plan

- W=8, mode 0, MSB, step every 4 clocks; source {dc=1, sel=0, 0xA5}, then empty -> get pulses once; cs_n[0] low; MOSI sampled on 8 rising edges = 1,0,1,0,0,1,0,1; spi_dc = 1; CS rises at the STOP step; clock idles at 0.
- Two words 0x3C and 0xC3, same sel, no empty gap -> 16 rising edges with CS continuously low; exactly 2 get pulses; second word's bits follow with no extra step.
- CS=4; words to sel 2 then sel 1 -> cs_n = 4'b1011 for the first word, all-high for ≥1 step, then 4'b1101; never two lines low at once.
- Mode 3, LSB=1, MISO looped to MOSI, send 0x3C -> clock idles 1; LSB first; out_valid pulse with out_data = 0x3C one clock after the last edge.
- W=12, mode 1, send 0xABC with MISO tied 1 -> 24 edges; out_data = 0xFFF.
- Reset asserted after 5 edges -> outputs at reset values within the same clock; no out_valid; after release with empty = 0, the next step issues get and a fresh word starts at edge 0.

Source files
------------

// File: rtl/spi_display_multi.sv
// Bit-bang SPI master for display command streams: pulls {dc, sel, data} words from a
// first-word-fall-through source and shifts them out one SPI edge per qualified step.
module spi_display_multi #(
    parameter int W    = 8,
    parameter int CS   = 1,
    parameter int CPOL = 0,
    parameter int CPHA = 0,
    parameter int LSB  = 0,
    parameter int SW   = (CS > 1) ? $clog2(CS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          step,
    input  logic          in_dc,
    input  logic [SW-1:0] in_sel,
    input  logic [W-1:0]  in_data,
    output logic          get,
    input  logic          empty,
    output logic [CS-1:0] spi_cs_n,
    output logic          spi_clock,
    output logic          spi_dc,
    output logic          spi_mosi,
    input  logic          spi_miso,
    output logic [W-1:0]  out_data,
    output logic          out_valid
);

    localparam int CW = $clog2(2 * W + 1);
    localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    tx_sh, rx_sh, rx_nx;
    logic [SW-1:0]   sel_q;
    logic            load, tick, last_edge, leading, drive_edge, sample_edge;

    function automatic logic first_bit(input logic [W-1:0] d);
        return (LSB != 0) ? d[0] : d[W-1];
    endfunction

    function automatic logic [W-1:0] shift_tx(input logic [W-1:0] d);
        return (LSB != 0) ? (d >> 1) : (d << 1);
    endfunction

    function automatic logic [W-1:0] rx_push(input logic [W-1:0] r, input logic b);
        return (LSB != 0) ? {b, r[W-1:1]} : {r[W-2:0], b};
    endfunction

    function automatic logic [CS-1:0] cs_decode(input logic [SW-1:0] s);
        logic [CS-1:0] r;
        for (int i = 0; i < CS; i++) r[i] = (s != SW'(i));
        return r;
    endfunction

    // Next-state and handshake; nothing may load or toggle while reset is held.
    always_comb begin
        state_nx  = state;
        get       = 1'b0;
        load      = 1'b0;
        tick      = 1'b0;
        last_edge = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: if (step && !empty) begin
                    get      = 1'b1;
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
                SHIFT: if (step) begin
                    tick = 1'b1;
                    if (cnt == LAST) begin
                        last_edge = 1'b1;
                        if (!empty && in_sel == sel_q) begin
                            get  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_nx = STOP;
                        end
                    end
                end
                STOP: if (step) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Edge about to be produced is leading when the count before it is even.
    assign leading     = ~cnt[0];
    assign drive_edge  = tick && ((CPHA != 0) ? leading : (!leading && !last_edge));
    assign sample_edge = tick && ((CPHA != 0) ? !leading : leading);
    assign rx_nx       = sample_edge ? rx_push(rx_sh, spi_miso) : rx_sh;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            spi_cs_n  <= '1;
            spi_clock <= 1'(CPOL);
            spi_dc    <= 1'b0;
            spi_mosi  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= 1'b0;
            if (tick) begin
                spi_clock <= ~spi_clock;
                cnt       <= cnt + CW'(1);
            end
            if (drive_edge) spi_mosi <= first_bit(tx_sh);
            if (last_edge) begin
                out_data  <= rx_nx;
                out_valid <= 1'b1;
                cnt       <= '0;
            end
            if (load) begin
                spi_cs_n <= cs_decode(in_sel);
                spi_dc   <= in_dc;
                cnt      <= '0;
                if (CPHA == 0) spi_mosi <= first_bit(in_data);
            end
            if (state == STOP && step) begin
                spi_cs_n <= '1;
                spi_mosi <= 1'b0;
            end
        end
    end

    // Shift registers and latched select carry no reset: they are always rewritten before use.
    always_ff @(posedge clock) begin
        rx_sh <= rx_nx;
        if (load) begin
            sel_q <= in_sel;
            tx_sh <= (CPHA == 0) ? shift_tx(in_data) : in_data;
        end else if (drive_edge) begin
            tx_sh <= shift_tx(tx_sh);
        end
    end

endmodule
